// File: rtl/oled_pkg.sv
// Shared definitions for the OLED command controller: opcodes, FSM states, address modes.
// Latency: n/a (package only).
// Backpressure: n/a; the controller accepts one byte per cycle and has no ready signal.
// Optional feature macro OLED_ADDR_MODES_EN selects vertical/page addressing in the users of this package.
package oled_pkg;

    localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
    localparam logic [7:0] OP_DISP_ON   = 8'hAF;
    localparam logic [7:0] OP_INV_OFF   = 8'hA6;
    localparam logic [7:0] OP_INV_ON    = 8'hA7;
    localparam logic [7:0] OP_CONTRAST  = 8'h81;
    localparam logic [7:0] OP_MEM_MODE  = 8'h20;
    localparam logic [7:0] OP_COL_ADDR  = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
    localparam logic [7:0] OP_MUX_RATIO = 8'hA8;
    localparam logic [7:0] OP_DISP_OFS  = 8'hD3;
    localparam logic [7:0] OP_CLK_DIV   = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE = 8'hD9;
    localparam logic [7:0] OP_COM_PINS  = 8'hDA;
    localparam logic [7:0] OP_VCOMH     = 8'hDB;
    localparam logic [7:0] OP_CHG_PUMP  = 8'h8D;

    typedef enum logic [1:0] {
        ST_CMD  = 2'd0,
        ST_ARG1 = 2'd1,
        ST_ARG2 = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_HORIZ = 2'd0,
        MODE_VERT  = 2'd1,
        MODE_PAGE  = 2'd2
    } mode_t;

    // Opcodes that are followed by at least one argument byte.
    function automatic logic takes_arg(input logic [7:0] op);
        case (op)
            OP_CONTRAST, OP_MEM_MODE, OP_COL_ADDR, OP_PAGE_ADDR,
            OP_MUX_RATIO, OP_DISP_OFS, OP_CLK_DIV, OP_PRECHARGE,
            OP_COM_PINS, OP_VCOMH, OP_CHG_PUMP: takes_arg = 1'b1;
            default:                            takes_arg = 1'b0;
        endcase
    endfunction

    // The reserved mode encoding 3 behaves as horizontal.
    function automatic mode_t decode_mode(input logic [1:0] arg);
        case (arg)
            2'd1:    decode_mode = MODE_VERT;
            2'd2:    decode_mode = MODE_PAGE;
            default: decode_mode = MODE_HORIZ;
        endcase
    endfunction

endpackage

// File: rtl/oled_addr_gen.sv
// Framebuffer position/window registers and the post-write advance logic.
// Latency: all loads and advances take effect on the clock edge of the requesting strobe.
// Backpressure: none; a strobe may arrive every cycle.
// Ports: clk_oled/reset; adv_i (advance after a write); col_win_i/page_win_i load a window
// from win_start_i/win_end_i; mode_ld_i/mode_i, pg_set_i, col_lo_i, col_hi_i, nib_i drive the
// optional addressing modes (macro OLED_ADDR_MODES_EN); col_o/page_o/mode_o report current state.
module oled_addr_gen
    import oled_pkg::*;
#(
    parameter int COLS  = 128,
    parameter int PAGES = 8
) (
    input  logic       clk_oled,
    input  logic       reset,
    input  logic       adv_i,
    input  logic       col_win_i,
    input  logic       page_win_i,
    input  logic [6:0] win_start_i,
    input  logic [6:0] win_end_i,
    input  logic       mode_ld_i,
    input  logic [1:0] mode_i,
    input  logic       pg_set_i,
    input  logic       col_lo_i,
    input  logic       col_hi_i,
    input  logic [3:0] nib_i,
    output logic [6:0] col_o,
    output logic [2:0] page_o,
    output logic [1:0] mode_o
);

    localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
    localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);

    logic [6:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [2:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic [6:0] col_nxt;
    logic [2:0] page_nxt;
    logic       col_at_end, page_at_end;
    mode_t      mode_cur;

`ifdef OLED_ADDR_MODES_EN
    mode_t mode_q, mode_d;
    assign mode_cur = mode_q;
`else
    // Without the optional modes the addressing is permanently horizontal.
    logic unused_cfg;
    assign mode_cur   = MODE_HORIZ;
    assign unused_cfg = ^{mode_ld_i, mode_i, pg_set_i, col_lo_i, col_hi_i, nib_i};
`endif

    assign col_at_end  = (col_q == col_end_q);
    assign page_at_end = (page_q == page_end_q);
    assign col_nxt     = col_at_end  ? col_start_q  : col_q + 7'd1;
    assign page_nxt    = page_at_end ? page_start_q : page_q + 3'd1;

    always_comb begin
        col_d        = col_q;
        page_d       = page_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
`ifdef OLED_ADDR_MODES_EN
        mode_d       = mode_q;
`endif
        if (adv_i) begin
            case (mode_cur)
                MODE_VERT: begin
                    page_d = page_nxt;
                    if (page_at_end) col_d = col_nxt;
                end
                MODE_PAGE: col_d = col_nxt;
                default: begin
                    col_d = col_nxt;
                    if (col_at_end) page_d = page_nxt;
                end
            endcase
        end
        // A written end below the start collapses the window to the start value.
        if (col_win_i) begin
            col_start_d = win_start_i;
            col_end_d   = (win_end_i < win_start_i) ? win_start_i : win_end_i;
            col_d       = win_start_i;
        end
        if (page_win_i) begin
            page_start_d = win_start_i[2:0];
            page_end_d   = (win_end_i[2:0] < win_start_i[2:0]) ? win_start_i[2:0] : win_end_i[2:0];
            page_d       = win_start_i[2:0];
        end
`ifdef OLED_ADDR_MODES_EN
        if (mode_ld_i) mode_d      = decode_mode(mode_i);
        if (pg_set_i)  page_d      = nib_i[2:0];
        if (col_lo_i)  col_d[3:0]  = nib_i;
        if (col_hi_i)  col_d[6:4]  = nib_i[2:0];
`endif
    end

    always_ff @(posedge clk_oled or posedge reset) begin
        if (reset) begin
            col_q        <= 7'd0;
            page_q       <= 3'd0;
            col_start_q  <= 7'd0;
            col_end_q    <= COL_LAST;
            page_start_q <= 3'd0;
            page_end_q   <= PAGE_LAST;
`ifdef OLED_ADDR_MODES_EN
            mode_q       <= MODE_HORIZ;
`endif
        end else begin
            col_q        <= col_d;
            page_q       <= page_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
`ifdef OLED_ADDR_MODES_EN
            mode_q       <= mode_d;
`endif
        end
    end

    assign col_o  = col_q;
    assign page_o = page_q;
    assign mode_o = mode_cur;

endmodule

// File: rtl/oled_cmd_ctrl.sv
// OLED SPI byte decoder: command FSM (CMD/ARG1/ARG2), panel config registers, framebuffer writes.
// Latency: config changes and the wr_en strobe appear one cycle after the byte strobe.
// Backpressure: none; byte_valid may be asserted every cycle without loss.
// Ports: clk_oled/reset (async active-high); byte_valid/byte_dc/byte_data from the SPI deserializer;
// wr_en/wr_addr {page,col}/wr_data to the framebuffer; display_on/invert_video/contrast config.
// Macro OLED_ADDR_MODES_EN enables vertical and page addressing plus the page-mode commands.
module oled_cmd_ctrl
    import oled_pkg::*;
#(
    parameter int COLS  = 128,
    parameter int PAGES = 8
) (
    input  logic       clk_oled,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic       byte_dc,
    input  logic [7:0] byte_data,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       display_on,
    output logic       invert_video,
    output logic [7:0] contrast
);

    state_t     state_q;
    logic [7:0] op_q;
    logic [6:0] arg1_q;
    logic       wr_en_q, disp_q, inv_q;
    logic [9:0] wr_addr_q;
    logic [7:0] wr_data_q, contrast_q;

    logic       cmd_stb, data_stb;
    logic       col_win, page_win, mode_ld, pg_set, col_lo, col_hi;
    logic [6:0] gen_col;
    logic [2:0] gen_page;
    logic [1:0] gen_mode;

    assign cmd_stb  = byte_valid & ~byte_dc;
    assign data_stb = byte_valid & byte_dc;

    // Window loads complete on the second argument; the first is held in arg1_q.
    assign col_win  = cmd_stb && (state_q == ST_ARG2) && (op_q == OP_COL_ADDR);
    assign page_win = cmd_stb && (state_q == ST_ARG2) && (op_q == OP_PAGE_ADDR);

`ifdef OLED_ADDR_MODES_EN
    logic in_page_cmd;
    assign in_page_cmd = cmd_stb && (state_q == ST_CMD) && (gen_mode == MODE_PAGE);
    assign mode_ld     = cmd_stb && (state_q == ST_ARG1) && (op_q == OP_MEM_MODE);
    assign pg_set      = in_page_cmd && (byte_data[7:3] == 5'b10110);
    assign col_lo      = in_page_cmd && (byte_data[7:4] == 4'h0);
    assign col_hi      = in_page_cmd && (byte_data[7:3] == 5'b00010);
`else
    logic unused_mode;
    assign mode_ld     = 1'b0;
    assign pg_set      = 1'b0;
    assign col_lo      = 1'b0;
    assign col_hi      = 1'b0;
    assign unused_mode = ^gen_mode;
`endif

    oled_addr_gen #(
        .COLS  (COLS),
        .PAGES (PAGES)
    ) u_addr_gen (
        .clk_oled    (clk_oled),
        .reset       (reset),
        .adv_i       (data_stb),
        .col_win_i   (col_win),
        .page_win_i  (page_win),
        .win_start_i (arg1_q),
        .win_end_i   (byte_data[6:0]),
        .mode_ld_i   (mode_ld),
        .mode_i      (byte_data[1:0]),
        .pg_set_i    (pg_set),
        .col_lo_i    (col_lo),
        .col_hi_i    (col_hi),
        .nib_i       (byte_data[3:0]),
        .col_o       (gen_col),
        .page_o      (gen_page),
        .mode_o      (gen_mode)
    );

    always_ff @(posedge clk_oled or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CMD;
            op_q       <= 8'h00;
            arg1_q     <= 7'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 10'd0;
            wr_data_q  <= 8'h00;
            disp_q     <= 1'b0;
            inv_q      <= 1'b0;
            contrast_q <= 8'h7F;
        end else begin
            wr_en_q <= 1'b0;
            if (data_stb) begin
                // Data always wins: any pending argument sequence is dropped.
                state_q   <= ST_CMD;
                wr_en_q   <= 1'b1;
                wr_addr_q <= {gen_page, gen_col};
                wr_data_q <= byte_data;
            end else if (cmd_stb) begin
                case (state_q)
                    ST_CMD: begin
                        case (byte_data)
                            OP_DISP_OFF: disp_q <= 1'b0;
                            OP_DISP_ON:  disp_q <= 1'b1;
                            OP_INV_OFF:  inv_q  <= 1'b0;
                            OP_INV_ON:   inv_q  <= 1'b1;
                            default: begin
                                if (takes_arg(byte_data)) begin
                                    op_q    <= byte_data;
                                    state_q <= ST_ARG1;
                                end
                            end
                        endcase
                    end
                    ST_ARG1: begin
                        if (op_q == OP_CONTRAST) contrast_q <= byte_data;
                        if (op_q == OP_COL_ADDR || op_q == OP_PAGE_ADDR) begin
                            arg1_q  <= byte_data[6:0];
                            state_q <= ST_ARG2;
                        end else begin
                            state_q <= ST_CMD;
                        end
                    end
                    default: state_q <= ST_CMD;
                endcase
            end
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign display_on   = disp_q;
    assign invert_video = inv_q;
    assign contrast     = contrast_q;

endmodule

// File: tb/tb_oled_cmd_ctrl.sv
// Directed bench for oled_cmd_ctrl: vector table plus hand sequences for timing and async reset.
// Latency: expects outputs to settle one cycle after each byte strobe.
// Backpressure: none; rows are applied back-to-back, one per cycle.
module tb_oled_cmd_ctrl;

    logic       clk_oled = 1'b0;
    logic       reset = 1'b1;
    logic       byte_valid = 1'b0;
    logic       byte_dc = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       display_on, invert_video;
    logic [7:0] contrast;

    oled_cmd_ctrl dut (
        .clk_oled     (clk_oled),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_dc      (byte_dc),
        .byte_data    (byte_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .display_on   (display_on),
        .invert_video (invert_video),
        .contrast     (contrast)
    );

    always #5 clk_oled = ~clk_oled;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic       dc;
        logic [7:0] dat;
        logic       we;
        logic [9:0] addr;
        logic [7:0] wd;
        logic       don;
        logic       inv;
        logic [7:0] con;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic       ex_don;
    logic       ex_inv;
    logic [7:0] ex_con;

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", nm, row, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic vld, input logic dc, input logic [7:0] dat,
                                input logic we, input logic [9:0] addr, input logic [7:0] wd);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dc = dc; v.dat = dat;
        v.we = we; v.addr = addr; v.wd = wd;
        v.don = ex_don; v.inv = ex_inv; v.con = ex_con;
        vecs.push_back(v);
    endfunction

    function automatic void ex(input logic don, input logic inv, input logic [7:0] con);
        ex_don = don; ex_inv = inv; ex_con = con;
    endfunction

    function automatic void r();
        ex(1'b0, 1'b0, 8'h7F);
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 10'd0, 8'h00);
    endfunction

    function automatic void c(input logic [7:0] b);
        add(1'b0, 1'b1, 1'b0, b, 1'b0, 10'd0, 8'h00);
    endfunction

    function automatic void d(input logic [7:0] b, input int pg, input int col);
        add(1'b0, 1'b1, 1'b1, b, 1'b1, {3'(pg), 7'(col)}, b);
    endfunction

    function automatic void idle();
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 10'd0, 8'h00);
    endfunction

    task automatic send(input logic dc, input logic [7:0] b);
        @(negedge clk_oled);
        byte_valid = 1'b1;
        byte_dc    = dc;
        byte_data  = b;
        @(posedge clk_oled);
        #1;
        byte_valid = 1'b0;
    endtask

    initial begin
        // ---- vector table ----
        r();
        ex(1, 0, 8'h7F); c(8'hAF);
        ex(1, 1, 8'h7F); c(8'hA7);
        idle();
        ex(0, 1, 8'h7F); c(8'hAE);
        ex(0, 0, 8'h7F); c(8'hA6);
        ex(1, 0, 8'h7F); c(8'hAF);
        c(8'h81);
        ex(1, 0, 8'h3C); c(8'h3C);
        c(8'h21); c(8'd10); c(8'd12);
        c(8'h22); c(8'd2);  c(8'd3);
        d(8'hD1, 2, 10); d(8'hD2, 2, 11); d(8'hD3, 2, 12);
        d(8'hD4, 3, 10); d(8'hD5, 3, 11); d(8'hD6, 3, 12);
        d(8'hD7, 2, 10);
        idle();
        c(8'hE3); d(8'hD8, 2, 11);
        c(8'hB3); c(8'h05); c(8'h12); d(8'hD9, 2, 12);
        c(8'hA8); c(8'hAE);
        ex(1, 1, 8'h3C); c(8'hA7);
        d(8'hDA, 3, 10);
        // contrast opener aborted by data
        r();
        c(8'h81); d(8'h55, 0, 0);
        ex(1, 0, 8'h7F); c(8'hAF);
        // two-argument opener aborted by data: window untouched
        c(8'h21); c(8'h05); d(8'h77, 0, 1);
        ex(1, 1, 8'h7F); c(8'hA7);
        // end below start clamps to start
        r();
        c(8'h21); c(8'd100); c(8'd50);
        d(8'hE1, 0, 100); d(8'hE2, 1, 100); d(8'hE3, 2, 100);
`ifdef OLED_ADDR_MODES_EN
        // vertical mode
        r();
        c(8'h20); c(8'h01);
        for (int p = 0; p < 8; p++) d(8'(p), p, 0);
        d(8'h08, 0, 1);
        // page mode with page-mode position commands
        c(8'h20); c(8'h02);
        c(8'hB5); c(8'h03); c(8'h12);
        d(8'hA0, 5, 35); d(8'hA1, 5, 36);
        // mode 3 behaves as horizontal: page advances on column wrap
        c(8'h20); c(8'h03);
        c(8'h21); c(8'd2); c(8'd3);
        d(8'hA2, 5, 2); d(8'hA3, 5, 3); d(8'hA4, 6, 2);
`endif

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk_oled);
            reset      = vecs[k].rst;
            byte_valid = vecs[k].rst ? 1'b0 : vecs[k].vld;
            byte_dc    = vecs[k].dc;
            byte_data  = vecs[k].dat;
            @(posedge clk_oled);
            #1;
            chk("wr_en", k, 32'(wr_en), 32'(vecs[k].we));
            if (vecs[k].we || vecs[k].rst) begin
                chk("wr_addr", k, 32'(wr_addr), 32'(vecs[k].addr));
                chk("wr_data", k, 32'(wr_data), 32'(vecs[k].wd));
            end
            chk("display_on", k, 32'(display_on), 32'(vecs[k].don));
            chk("invert_video", k, 32'(invert_video), 32'(vecs[k].inv));
            chk("contrast", k, 32'(contrast), 32'(vecs[k].con));
        end
        @(negedge clk_oled);
        byte_valid = 1'b0;
        reset      = 1'b0;

        // ---- hand sequence: strobe timing and async reset mid-command ----
        @(negedge clk_oled); reset = 1'b1;
        @(negedge clk_oled); reset = 1'b0;
        @(negedge clk_oled);
        byte_valid = 1'b1; byte_dc = 1'b0; byte_data = 8'hAF;
        #1;
        chk("don_before_edge", 1000, 32'(display_on), 32'd0);
        @(posedge clk_oled); #1;
        byte_valid = 1'b0;
        chk("don_after_edge", 1001, 32'(display_on), 32'd1);
        send(1'b0, 8'hA7);
        send(1'b0, 8'h81); send(1'b0, 8'h20);
        chk("contrast_set", 1002, 32'(contrast), 32'h20);
        send(1'b0, 8'h21); send(1'b0, 8'd5); send(1'b0, 8'd6);
        send(1'b1, 8'h11);
        chk("win_write_addr", 1003, 32'(wr_addr), 32'(10'd5));
        send(1'b0, 8'h22);
        // async reset in the low phase, no clock edge involved
        #2 reset = 1'b1;
        #1;
        chk("rst_contrast", 1004, 32'(contrast), 32'h7F);
        chk("rst_display_on", 1005, 32'(display_on), 32'd0);
        chk("rst_invert", 1006, 32'(invert_video), 32'd0);
        chk("rst_wr_addr", 1007, 32'(wr_addr), 32'd0);
        chk("rst_wr_en", 1008, 32'(wr_en), 32'd0);
        @(negedge clk_oled); reset = 1'b0;
        send(1'b0, 8'hAF);
        chk("post_rst_opcode", 1009, 32'(display_on), 32'd1);
        send(1'b1, 8'h99);
        chk("post_rst_we", 1010, 32'(wr_en), 32'd1);
        chk("post_rst_addr", 1011, 32'(wr_addr), 32'd0);
        chk("post_rst_data", 1012, 32'(wr_data), 32'h99);
        send(1'b1, 8'h9A);
        chk("post_rst_addr2", 1013, 32'(wr_addr), 32'd1);
        @(posedge clk_oled); #1;
        chk("we_single_cycle", 1014, 32'(wr_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_cmd_ctrl.md
OLED_CMD_CTRL -- requirements
Module: oled_cmd_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 128, meaning display width in columns (7-bit column index).
REQ-002 SHALL have parameter PAGES, default 8, meaning display height in 8-pixel pages (3-bit page index).
REQ-003 SHALL have port clk_oled, input, 1, the single clock; all state is in this domain.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port byte_valid, input, 1, one-cycle strobe marking a complete deserialized SPI byte.
REQ-006 SHALL have port byte_dc, input, 1, D/C level latched with the byte (0 command, 1 data).
REQ-007 SHALL have port byte_data, input, 8, received byte.
REQ-008 SHALL have port wr_en, output, 1, framebuffer write strobe.
REQ-009 SHALL have port wr_addr, output, 10, framebuffer address {page[2:0], col[6:0]}.
REQ-010 SHALL have port wr_data, output, 8, framebuffer byte (bit n = row n of page).
REQ-011 SHALL have ports display_on (1), invert_video (1) and contrast (8), outputs, current panel configuration.

Function
REQ-012 SHALL decode commands with FSM states CMD, ARG1, ARG2; byte_valid with byte_dc=0 in CMD selects the opcode.
REQ-013 SHALL treat 0xAE/0xAF as display_on=0/1, and 0xA6/0xA7 as invert_video=0/1; these take effect on the cycle after the strobe.
REQ-014 SHALL go from CMD to ARG1 on 0x81 (contrast), 0x20 (mode), 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB and 0x8D. The next command byte is consumed as the argument and the FSM returns to CMD; only 0x81 and 0x20 arguments are stored.
REQ-015 SHALL go CMD->ARG1->ARG2->CMD on 0x21 (column start/end, 7 bits) and 0x22 (page start/end, 3 bits). Reaching ARG2 completion SHALL also load the current column/page with the new start value.
REQ-016 SHALL clamp the end value to the start value when the written end is less than the start.
REQ-017 SHALL ignore all other command bytes in CMD without changing state.
REQ-018 SHALL, when byte_valid with byte_dc=1 arrives in any state, return the FSM to CMD (aborting any pending argument) and issue a write.
REQ-019 SHALL assert wr_en for exactly one cycle, one cycle after the data strobe, with wr_addr equal to the pre-advance position and wr_data=byte_data.
REQ-020 SHALL, in horizontal mode, advance col after each write. When col==col_end, col SHALL wrap to col_start and page SHALL advance, wrapping from page_end to page_start.
REQ-021 SHALL, in vertical mode, advance page first. When page==page_end, page SHALL wrap to page_start and col SHALL advance, wrapping from col_end to col_start.
REQ-022 SHALL, in page mode, advance col and wrap from col_end to col_start with the page unchanged.
REQ-023 SHALL, in page mode, treat 0xB0-0xB7 as setting the current page, 0x00-0x0F as setting col[3:0] and 0x10-0x17 as setting col[6:4].
REQ-024 SHALL treat a mode argument of 3 as horizontal.
REQ-025 SHALL ignore byte_valid=0 cycles completely; back-to-back strobes every cycle SHALL be supported without loss.

Reset
REQ-026 SHALL on reset force: FSM=CMD, wr_en=0, wr_addr=0, wr_data=0, display_on=0, invert_video=0, contrast=0x7F, mode=horizontal, col/page=0, col_start=0, col_end=127, page_start=0, page_end=7.
REQ-027 SHALL abandon any in-progress argument sequence when reset asserts mid-command; no write is issued for the aborted sequence.

Configuration
REQ-028 SHALL, with OLED_ADDR_MODES_EN defined, implement the vertical and page modes and the page-mode commands (REQ-021 to REQ-023).
REQ-029 SHALL, without OLED_ADDR_MODES_EN, keep the mode fixed at horizontal. The 0x20 argument SHALL still be consumed but discarded, and 0x00-0x1F and 0xB0-0xB7 SHALL be ignored.

Structure
REQ-030 SHALL place opcode constants, the FSM state enum and the address-mode enum in shared package oled_pkg.
REQ-031 SHALL place the position/window registers and advance logic in sub-module oled_addr_gen; the decode FSM stays in oled_cmd_ctrl.

Verification
REQ-032 Stimulus: reset, then cmd 0xAF, 0xA7 -> display_on=1 and invert_video=1 one cycle after each strobe; contrast=0x7F.
REQ-033 Stimulus: cmd 0x21,10,12; 0x22,2,3; then 7 data bytes -> wr_addr cols 10,11,12 on page 2, then 10,11,12 on page 3, then col 10 on page 2.
REQ-034 Stimulus (macro defined): 0x20,1, full window, 9 data bytes -> addresses (p0,c0) through (p7,c0), then (p0,c1).
REQ-035 Stimulus: cmd 0x81, then a data byte 0x55 before any argument -> FSM returns to CMD, contrast stays 0x7F, one write of 0x55 at address 0.
REQ-036 Stimulus: cmd 0x21,100,50 -> col_end=100; 3 data bytes all write col 100.
REQ-037 Stimulus: reset asserted between 0x22 and its first argument -> all registers at reset values, next command byte decoded as an opcode.
